// File: rtl/serial_mag_comp.sv
// Bit-serial unsigned magnitude comparator: feeds a 1-bit comp cell MSB first,
// stops at the first differing bit and reports a registered result with done.
module serial_mag_comp #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             greater,
    output logic             lesser,
    output logic             equal
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [WIDTH-1:0] sa, sb;
    logic [CW-1:0]    cnt;
    logic             c_gt, c_lt, c_eq;
    logic             finish;

    comp u_comp (
        .a       (sa[WIDTH-1]),
        .b       (sb[WIDTH-1]),
        .greater (c_gt),
        .lesser  (c_lt),
        .equal   (c_eq)
    );

    // A comparison ends on the first differing bit, or after the LSB if all matched.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_nxt = state;
        finish    = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = CMP;
            CMP: begin
                if (c_gt || c_lt || (c_eq && cnt == '0)) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa      <= '0;
            sb      <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            greater <= 1'b0;
            lesser  <= 1'b0;
            equal   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sa      <= a_in;
                        sb      <= b_in;
                        cnt     <= CW'(WIDTH - 1);
                        greater <= 1'b0;
                        lesser  <= 1'b0;
                        equal   <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                CMP: begin
                    if (finish) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        // Priority: greater, then lesser, then equal on the last bit.
                        if (c_gt)      greater <= 1'b1;
                        else if (c_lt) lesser  <= 1'b1;
                        else           equal   <= 1'b1;
                    end else begin
                        sa  <= {sa[WIDTH-2:0], 1'b0};
                        sb  <= {sb[WIDTH-2:0], 1'b0};
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// 1-bit magnitude comparator cell.
module comp (
    input  logic a,
    input  logic b,
    output logic greater,
    output logic lesser,
    output logic equal
);
    assign greater = a & ~b;
    assign lesser  = ~a & b;
    assign equal   = ~(a ^ b);
endmodule
